axis_soft_volume: RTL and testbench

AXIS_SOFT_VOLUME -- requirements
Module: axis_soft_volume

---
 rtl/audio_pkg.sv | 27 ++
 rtl/gain_ramp.sv | 75 +++++++
 rtl/axis_soft_volume.sv | 124 ++++++++++++
 tb/tb_axis_soft_volume.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and helpers for the soft-volume audio path: volume FSM states,
// default widths and the switch-to-gain target mapping.
package audio_pkg;

   typedef enum logic [1:0] {
      ST_MUTED     = 2'd0,
      ST_SETTLED   = 2'd1,
      ST_RAMP_UP   = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } vol_state_t;

   localparam int DEF_DATA_WIDTH   = 24;
   localparam int DEF_CHANNELS     = 2;
   localparam int DEF_SWITCH_WIDTH = 4;
   localparam int DEF_GAIN_WIDTH   = 16;
   localparam int DEF_RAMP_STEP    = 64;

   // The switch value lands just below the Q1 sign/integer bit, so full scale stays under 1.0.
   function automatic logic [31:0] map_target(input logic [31:0] sw,
                                              input logic        mute,
                                              input int          sw_width,
                                              input int          gain_width);
      if (mute) return '0;
      return sw << (gain_width - 1 - sw_width);
   endfunction

endpackage

// File: rtl/gain_ramp.sv
// Frame-rate gain ramp: moves the gain toward the switch/mute target by a fixed
// step on every frame boundary and reports the resulting volume state.
module gain_ramp
   import audio_pkg::*;
#(
   parameter int SWITCH_WIDTH = DEF_SWITCH_WIDTH,
   parameter int GAIN_WIDTH   = DEF_GAIN_WIDTH,
   parameter int RAMP_STEP    = DEF_RAMP_STEP
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SWITCH_WIDTH-1:0] sw,
   input  logic                    mute,
   input  logic                    frame_end,
   output logic [GAIN_WIDTH-1:0]   gain,
   output logic                    ramping,
   output logic                    muted
);

   localparam logic [GAIN_WIDTH-1:0] STEP = GAIN_WIDTH'(RAMP_STEP);

   vol_state_t            state, state_next;
   logic [GAIN_WIDTH-1:0] target, gain_next;
   logic                  ramping_next, muted_next;

   assign target = GAIN_WIDTH'(map_target(32'(sw), mute, SWITCH_WIDTH, GAIN_WIDTH));

   // Differences are compared before stepping so the gain can never overshoot or wrap.
   always_comb begin
      gain_next = gain;
      if (frame_end) begin
         if (gain < target)
            gain_next = (target - gain > STEP) ? gain + STEP : target;
         else if (gain > target)
            gain_next = (gain - target > STEP) ? gain - STEP : target;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_MUTED;
         gain  <= '0;
      end else begin
         state <= state_next;
         gain  <= gain_next;
      end
   end

   always_comb begin
      state_next = state;
      if (frame_end) begin
         if (gain_next == '0 && target == '0) state_next = ST_MUTED;
         else if (gain_next == target)        state_next = ST_SETTLED;
         else if (gain_next < target)         state_next = ST_RAMP_UP;
         else                                 state_next = ST_RAMP_DOWN;
      end
   end

   always_comb begin
      ramping_next = (state_next == ST_RAMP_UP) || (state_next == ST_RAMP_DOWN);
      muted_next   = (state_next == ST_MUTED);
   end

   // Flags are registered alongside the state so they change on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         ramping <= 1'b0;
         muted   <= 1'b1;
      end else begin
         ramping <= ramping_next;
         muted   <= muted_next;
      end
   end

endmodule

// File: rtl/axis_soft_volume.sv
// AXI-Stream soft volume: two-stage (register, multiply) pipeline scaling each
// sample by a per-frame ramped gain, with frame-length error detection.
module axis_soft_volume
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int CHANNELS     = DEF_CHANNELS,
   parameter int SWITCH_WIDTH = DEF_SWITCH_WIDTH,
   parameter int GAIN_WIDTH   = DEF_GAIN_WIDTH,
   parameter int RAMP_STEP    = DEF_RAMP_STEP
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SWITCH_WIDTH-1:0] sw,
   input  logic                    mute,
   input  logic [DATA_WIDTH-1:0]   s_axis_data,
   input  logic                    s_axis_valid,
   output logic                    s_axis_ready,
   input  logic                    s_axis_last,
   output logic [DATA_WIDTH-1:0]   m_axis_data,
   output logic                    m_axis_valid,
   input  logic                    m_axis_ready,
   output logic                    m_axis_last,
   output logic                    ramping,
   output logic                    muted,
   output logic                    frame_err
);

   localparam int              CNT_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);

   logic                         advance, accept, frame_end;
   logic [GAIN_WIDTH-1:0]        gain;
   logic signed [DATA_WIDTH-1:0] data_p1, data_p2;
   logic [GAIN_WIDTH-1:0]        gain_p1;
   logic                         last_p1, last_p2;
   logic                         vld_p1, vld_p2;
   logic [CNT_W-1:0]             chan_cnt;
   logic                         frame_err_q;

   // Gain is unsigned Q1.x below 1.0, so the shifted product always fits DATA_WIDTH.
   function automatic logic signed [DATA_WIDTH-1:0] scale_sample(
      input logic signed [DATA_WIDTH-1:0] d,
      input logic [GAIN_WIDTH-1:0]        g);
      logic signed [DATA_WIDTH+GAIN_WIDTH:0] prod;
      prod = d * $signed({1'b0, g});
      prod = prod >>> (GAIN_WIDTH - 1);
      return prod[DATA_WIDTH-1:0];
   endfunction

   assign advance      = !vld_p2 || m_axis_ready;
   assign s_axis_ready = advance;
   assign accept       = s_axis_valid && advance;
   assign frame_end    = accept && s_axis_last;

   gain_ramp #(
      .SWITCH_WIDTH (SWITCH_WIDTH),
      .GAIN_WIDTH   (GAIN_WIDTH),
      .RAMP_STEP    (RAMP_STEP)
   ) u_gain_ramp (
      .clk       (clk),
      .reset     (reset),
      .sw        (sw),
      .mute      (mute),
      .frame_end (frame_end),
      .gain      (gain),
      .ramping   (ramping),
      .muted     (muted)
   );

   // Stage p1: capture sample with the gain in force at acceptance
   always_ff @(posedge clk) begin
      if (reset)        vld_p1 <= 1'b0;
      else if (advance) vld_p1 <= s_axis_valid;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         data_p1 <= s_axis_data;
         gain_p1 <= gain;
         last_p1 <= s_axis_last;
      end
   end

   // Stage p2: multiply and hold for the downstream handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p2  <= 1'b0;
         data_p2 <= '0;
         last_p2 <= 1'b0;
      end else if (advance) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            data_p2 <= scale_sample(data_p1, gain_p1);
            last_p2 <= last_p1;
         end
      end
   end

   assign m_axis_valid = vld_p2;
   assign m_axis_data  = data_p2;
   assign m_axis_last  = last_p2;

   // A misplaced or missing last is flagged once and the counter realigns on the next frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         chan_cnt    <= '0;
         frame_err_q <= 1'b0;
      end else if (accept) begin
         if (s_axis_last) begin
            chan_cnt <= '0;
            if (chan_cnt != LAST_CH) frame_err_q <= 1'b1;
         end else if (chan_cnt == LAST_CH) begin
            chan_cnt    <= '0;
            frame_err_q <= 1'b1;
         end else begin
            chan_cnt <= chan_cnt + CNT_W'(1);
         end
      end
   end

   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_axis_soft_volume.sv
// Bench for axis_soft_volume: random and directed streams against a frame-level
// gain model, with per-cycle output, flag and handshake comparison.
module tb_axis_soft_volume;

   localparam int DW   = 24;
   localparam int CH   = 2;
   localparam int SWW  = 4;
   localparam int GW   = 16;
   localparam int STEP = 64;

   logic           clk = 1'b0;
   logic           reset;
   logic [SWW-1:0] sw;
   logic           mute;
   logic [DW-1:0]  s_axis_data;
   logic           s_axis_valid;
   logic           s_axis_ready;
   logic           s_axis_last;
   logic [DW-1:0]  m_axis_data;
   logic           m_axis_valid;
   logic           m_axis_ready;
   logic           m_axis_last;
   logic           ramping;
   logic           muted;
   logic           frame_err;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] out_log[$];

   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;
   bit   mon_en = 0;
   bit   rst_seen = 0;
   bit   hold_pend = 0;
   logic [DW-1:0] hold_d;
   logic          hold_l;

   int   g_m = 0;
   int   cnt_m = 0;
   bit   err_m = 0;
   bit   ramp_m = 0;
   bit   mute_m = 1;

   always #5 clk = ~clk;

   axis_soft_volume #(
      .DATA_WIDTH   (DW),
      .CHANNELS     (CH),
      .SWITCH_WIDTH (SWW),
      .GAIN_WIDTH   (GW),
      .RAMP_STEP    (STEP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sw           (sw),
      .mute         (mute),
      .s_axis_data  (s_axis_data),
      .s_axis_valid (s_axis_valid),
      .s_axis_ready (s_axis_ready),
      .s_axis_last  (s_axis_last),
      .m_axis_data  (m_axis_data),
      .m_axis_valid (m_axis_valid),
      .m_axis_ready (m_axis_ready),
      .m_axis_last  (m_axis_last),
      .ramping      (ramping),
      .muted        (muted),
      .frame_err    (frame_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Frame-level reference: gain moves toward the target by at most STEP per accepted frame end.
   task automatic model_accept(input logic [DW-1:0] d, input logic l,
                               input logic [SWW-1:0] swv, input logic mv);
      int     tgt;
      longint sd, p;
      exp_t   e;
      tgt = mv ? 0 : (int'(swv) << (GW - 1 - SWW));
      sd  = longint'($signed(d));
      p   = (sd * longint'(g_m)) >>> (GW - 1);
      e.d = DW'(p);
      e.l = l;
      q.push_back(e);
      if (l) begin
         if (cnt_m != CH - 1) err_m = 1;
         cnt_m = 0;
         if (g_m < tgt)      g_m = (g_m + STEP > tgt) ? tgt : g_m + STEP;
         else if (g_m > tgt) g_m = (g_m - STEP < tgt) ? tgt : g_m - STEP;
         mute_m = (g_m == 0) && (tgt == 0);
         ramp_m = (g_m != tgt);
      end else if (cnt_m == CH - 1) begin
         err_m = 1;
         cnt_m = 0;
      end else begin
         cnt_m++;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_seen) begin
            chk("rst_m_valid", m_axis_valid, 0);
            chk("rst_m_data", m_axis_data, 0);
            chk("rst_m_last", m_axis_last, 0);
         end
         chk("ramping", ramping, ramp_m);
         chk("muted", muted, mute_m);
         chk("frame_err", frame_err, err_m);
         chk("s_ready", s_axis_ready, !m_axis_valid || m_axis_ready);
         if (hold_pend && !rst_seen) begin
            chk("hold_valid", m_axis_valid, 1);
            chk("hold_data", m_axis_data, hold_d);
            chk("hold_last", m_axis_last, hold_l);
         end
         if (reset) begin
            q.delete();
            g_m = 0; cnt_m = 0; err_m = 0; ramp_m = 0; mute_m = 1;
            hold_pend = 0;
         end else begin
            if (m_axis_valid && m_axis_ready) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_beat: got data %h, expected no beat", m_axis_data);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("out_data", m_axis_data, e.d);
                  chk("out_last", m_axis_last, e.l);
               end
               out_log.push_back(m_axis_data);
            end
            hold_pend = m_axis_valid && !m_axis_ready;
            hold_d    = m_axis_data;
            hold_l    = m_axis_last;
            if (s_axis_valid && s_axis_ready) model_accept(s_axis_data, s_axis_last, sw, mute);
         end
         rst_seen = reset;
      end
   end

   initial begin
      m_axis_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_axis_ready = 1'b1;
            1:       m_axis_ready = ($urandom_range(3) != 0);
            default: m_axis_ready = 1'b0;
         endcase
      end
   end

   // Called at posedge+1; returns at posedge+1 after the acceptance edge.
   task automatic send_beat(input logic [DW-1:0] d, input logic l);
      bit acc;
      int n;
      s_axis_data  = d;
      s_axis_last  = l;
      s_axis_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         acc = s_axis_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      chk("send_accepted", acc, 1);
      s_axis_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [DW-1:0] a, input logic [DW-1:0] b);
      send_beat(a, 1'b0);
      send_beat(b, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_pending", q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      s_axis_valid = 1'b0;
      s_axis_data  = '0;
      s_axis_last  = 1'b0;
      sw   = 4'hF;
      mute = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_muted", muted, 1);
      chk("reset_ramping", ramping, 0);
      chk("reset_valid", m_axis_valid, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_data", m_axis_data, 0);
      reset = 1'b0;

      // Ramp up from 0 to full scale
      out_log.delete();
      send_frame(24'h400000, 24'h400000);
      send_frame(24'h400000, 24'h400000);
      chk("ramp_up_flag", ramping, 1);
      for (int i = 0; i < 479; i++) send_frame(24'h400000, 24'h400000);
      drain();
      chk("a_frame1_c0", out_log[0], 24'h000000);
      chk("a_frame1_c1", out_log[1], 24'h000000);
      chk("a_frame2_c0", out_log[2], 24'h002000);
      chk("a_frame2_c1", out_log[3], 24'h002000);
      chk("a_final", out_log[961], 24'h3C0000);
      chk("a_settled_ramping", ramping, 0);
      chk("a_settled_muted", muted, 0);

      // Mute ramps down to zero
      mute = 1'b1;
      out_log.delete();
      for (int i = 0; i < 481; i++) send_frame(24'h400000, 24'h400000);
      drain();
      chk("b_first", out_log[0], 24'h3C0000);
      chk("b_second", out_log[2], 24'h3BE000);
      chk("b_final", out_log[961], 24'h000000);
      chk("b_muted", muted, 1);
      chk("b_ramping", ramping, 0);

      // Half gain with random data and random backpressure
      mute = 1'b0;
      sw = 4'h8;
      rdy_mode = 1;
      for (int i = 0; i < 260; i++) send_frame(DW'($urandom), DW'($urandom));
      drain();
      rdy_mode = 0;
      @(posedge clk);
      #1;
      chk("c_settled_ramping", ramping, 0);
      chk("c_settled_muted", muted, 0);
      send_beat(24'hC00000, 1'b0);
      @(negedge clk);
      chk("lat_cycle1_valid", m_axis_valid, 0);
      @(negedge clk);
      chk("lat_cycle2_valid", m_axis_valid, 1);
      chk("lat_data", m_axis_data, 24'hE00000);
      @(posedge clk);
      #1;
      send_beat(24'hC00000, 1'b1);
      drain();

      // Five-cycle downstream stall during a continuous stream
      fork
         begin
            for (int i = 0; i < 12; i++) send_frame(DW'($urandom), DW'($urandom));
         end
         begin
            repeat (6) @(posedge clk);
            rdy_mode = 2;
            repeat (3) @(negedge clk);
            chk("stall_s_ready", s_axis_ready, 0);
            chk("stall_m_valid", m_axis_valid, 1);
            repeat (3) @(posedge clk);
            rdy_mode = 0;
         end
      join
      drain();

      // Random target changes, including downward ramps
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         if (i % 10 == 0) begin
            sw   = SWW'($urandom);
            mute = ($urandom_range(3) == 0);
         end
         send_frame(DW'($urandom), DW'($urandom));
      end
      drain();
      rdy_mode = 0;
      @(posedge clk);
      #1;

      // Early last on channel 0 sets the sticky error
      send_beat(24'h123456, 1'b1);
      chk("ferr_set", frame_err, 1);
      for (int i = 0; i < 3; i++) send_frame(DW'($urandom), DW'($urandom));
      chk("ferr_sticky", frame_err, 1);
      drain();

      // Reset with beats held in the pipe
      sw = 4'hF;
      mute = 1'b0;
      for (int i = 0; i < 5; i++) send_frame(24'h400000, 24'h400000);
      drain();
      rdy_mode = 2;
      @(posedge clk);
      #1;
      send_beat(24'h111111, 1'b0);
      send_beat(24'h222222, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rstmid_valid", m_axis_valid, 0);
      chk("rstmid_muted", muted, 1);
      chk("rstmid_ramping", ramping, 0);
      chk("rstmid_frame_err", frame_err, 0);
      rdy_mode = 0;
      @(posedge clk);
      #1;
      out_log.delete();
      send_frame(24'h400000, 24'h400000);
      send_frame(24'h400000, 24'h400000);
      drain();
      chk("restart_frame1", out_log[0], 24'h000000);
      chk("restart_frame2", out_log[2], 24'h002000);
      chk("restart_log_len", out_log.size(), 4);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
